// File: rtl/lms_pkg.sv
// Shared definitions for the LMS weight-update block: parameter defaults and
// the sequencing FSM encoding.
package lms_pkg;
    localparam int NTAPS_DEF = 8;
    localparam int DW_DEF    = 10;
    localparam int WW_DEF    = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/lms_weight_update_sat_add.sv
// Saturating signed add/subtract of a DW-bit delta onto a WW-bit weight,
// done at WW+1 bits and clamped back to the WW-bit range.
module sat_add
    import lms_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic signed [WW-1:0] a,
    input  logic signed [DW-1:0] delta,
    input  logic                 sub,
    output logic signed [WW-1:0] sum,
    output logic                 sat
);
    localparam logic signed [WW-1:0] MAX_V = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V = {1'b1, {(WW-1){1'b0}}};

    logic signed [WW:0] a_ext;
    logic signed [WW:0] d_ext;
    logic signed [WW:0] s_ext;

    always_comb begin
        a_ext = {a[WW-1], a};
        d_ext = {{(WW+1-DW){delta[DW-1]}}, delta};
        s_ext = sub ? (a_ext - d_ext) : (a_ext + d_ext);
        // The two top bits disagree exactly when the result left the WW-bit range.
        sat   = s_ext[WW] ^ s_ext[WW-1];
        if (!sat) begin
            sum = s_ext[WW-1:0];
        end else if (s_ext[WW]) begin
            sum = MIN_V;
        end else begin
            sum = MAX_V;
        end
    end
endmodule

// File: rtl/lms_weight_update.sv
// Sign-error LMS weight update: each accepted sample/error pair shifts the
// delay line, then walks the taps one per cycle applying w += sign(e)*(x>>>mu).
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int WW    = WW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       x_in,
    input  logic [DW-1:0]       err_in,
    input  logic [3:0]          mu_shift,
    input  logic                freeze,
    output logic [NTAPS*WW-1:0] weights,
    output logic                done,
    output logic                sat_flag
);
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [DW-1:0] x_q [NTAPS];
    logic signed [DW-1:0] x_d [NTAPS];
    logic signed [WW-1:0] w_q [NTAPS];
    logic signed [WW-1:0] w_d [NTAPS];
    logic signed [DW-1:0] err_q, err_d;
    logic [3:0]           mu_q, mu_d;
    logic                 frz_q, frz_d;
    logic                 sat_q, sat_d;

    logic signed [DW-1:0] delta;
    logic signed [WW-1:0] w_new;
    logic                 add_sat;
    logic                 apply;

    // Arithmetic shift by >= DW naturally collapses to 0 or -1.
    assign delta = x_q[idx_q] >>> mu_q;
    assign apply = !frz_q && (err_q != '0);

    sat_add #(.DW(DW), .WW(WW)) u_sat_add (
        .a     (w_q[idx_q]),
        .delta (delta),
        .sub   (err_q[DW-1]),
        .sum   (w_new),
        .sat   (add_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        mu_d    = mu_q;
        frz_d   = frz_q;
        sat_d   = sat_q;
        for (int k = 0; k < NTAPS; k++) begin
            x_d[k] = x_q[k];
            w_d[k] = w_q[k];
        end

        if (clr) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            sat_d   = 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x_d[k] = '0;
                w_d[k] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_d[0] = x_in;
                        for (int k = 1; k < NTAPS; k++) begin
                            x_d[k] = x_q[k-1];
                        end
                        err_d   = err_in;
                        mu_d    = mu_shift;
                        frz_d   = freeze;
                        idx_d   = '0;
                        state_d = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (apply) begin
                        w_d[idx_q] = w_new;
                        if (add_sat) begin
                            sat_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            mu_q    <= '0;
            frz_q   <= 1'b0;
            sat_q   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            mu_q    <= mu_d;
            frz_q   <= frz_d;
            sat_q   <= sat_d;
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= x_d[k];
                w_q[k] <= w_d[k];
            end
        end
    end

    // A clear arriving in the DONE cycle aborts that pass, so the pulse is masked.
    assign in_ready = (state_q == ST_IDLE);
    assign done     = (state_q == ST_DONE) && !clr;
    assign sat_flag = sat_q;

    always_comb begin
        weights = '0;
        for (int k = 0; k < NTAPS; k++) begin
            weights[k*WW +: WW] = w_q[k];
        end
    end
endmodule

// File: doc/lms_weight_update.md
LMS_WEIGHT_UPDATE -- requirements
Module: lms_weight_update

Interface
REQ-001 SHALL have parameter NTAPS, default 8, number of filter taps/weights (>=2).
REQ-002 SHALL have parameter DW, default 10, signed sample/error width.
REQ-003 SHALL have parameter WW, default 10, signed weight width (WW >= DW).
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of weights and delay line.
REQ-007 SHALL have port in_valid  input  1  new sample/error pair offered.
REQ-008 SHALL have port in_ready  output  1  block can accept a pair.
REQ-009 SHALL have port x_in  input  DW  signed new input sample.
REQ-010 SHALL have port err_in  input  DW  signed error for this update.
REQ-011 SHALL have port mu_shift  input  4  step size as a right-shift amount.
REQ-012 SHALL have port freeze  input  1  1 = shift delay line only, no weight change.
REQ-013 SHALL have port weights  output  NTAPS*WW  packed weights, w[k] at bits [k*WW +: WW].
REQ-014 SHALL have port done  output  1  one-cycle pulse, update pass complete.
REQ-015 SHALL have port sat_flag  output  1  sticky, set when any weight saturates.

Function
REQ-016 SHALL implement FSM states IDLE, UPDATE, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept on the edge with in_valid && in_ready: shift x_in into delay line x[0] (x[k] moves to x[k+1], x[NTAPS-1] discarded), latch err_in, mu_shift and freeze, set idx=0, go to UPDATE.
REQ-018 SHALL in UPDATE write w[idx] on each edge, idx incrementing 0..NTAPS-1, one tap per cycle; after the edge that writes w[NTAPS-1], go to DONE.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE; accept-to-done latency NTAPS+1 cycles; throughput one pair per NTAPS+2 cycles.
REQ-020 SHALL compute delta = x[idx] >>> mu_shift (arithmetic); w_new = w + delta if err>0, w - delta if err<0, w unchanged if err==0.
REQ-021 SHALL compute the sum at WW+1 bits with sign-extended operands and saturate to [-2^(WW-1), 2^(WW-1)-1].
REQ-022 SHALL set sat_flag when a clamp occurs; it is cleared only by rst or clr.
REQ-023 SHALL leave weights unchanged when latched freeze=1, still running the full UPDATE/DONE sequence.
REQ-024 SHALL treat mu_shift >= DW as giving delta 0 for non-negative x and -1 for negative x.
REQ-025 SHALL give clr priority over in_valid in every state: zero all weights, delay line and sat_flag, go to IDLE, suppress done; an in-progress pass is aborted.
REQ-026 SHALL ignore in_valid outside IDLE; x_in/err_in changes during UPDATE do not affect the pass.
REQ-027 SHALL drive weights directly from the weight registers; a weight update is visible the cycle after its write edge.

Reset
REQ-028 SHALL on rst asynchronously force: state IDLE, idx 0, all weights 0, delay line 0, done 0, sat_flag 0; in_ready is 1 during and after reset.
REQ-029 SHALL, if rst asserts mid-pass, discard the pass entirely; no done pulse follows release.

Structure
REQ-030 SHALL place the FSM state enum and parameter defaults (NTAPS, DW, WW) in shared package lms_pkg.
REQ-031 SHALL implement the widen/add/clamp path as one sub-module sat_add (WW-bit signed a, DW-bit signed delta, add/sub select, outputs WW sum and sat).

Verification
REQ-032 SHALL cover: reset, one pair x_in=64, err_in=5, mu_shift=2 -> w[0]=16, other weights 0, done in cycle NTAPS+1 after accept.
REQ-033 SHALL cover: weights preloaded to 511 (WW=10) via repeated updates, x=256, err=+1, mu=0 -> w[0]=511, sat_flag=1 and stays 1.
REQ-034 SHALL cover: err_in=0 or freeze=1 with x=100 -> weights unchanged, done still pulses, delay line shifted (next pass updates w[1] from 100).
REQ-035 SHALL cover: x=-3, mu_shift=15, err=+1 -> w[0] decrements by 1; x=3 same settings -> no change.
REQ-036 SHALL cover: clr asserted at UPDATE idx=3 -> all weights 0, no done, in_ready=1 next cycle; in_valid held during UPDATE -> not accepted until IDLE.
REQ-037 SHALL cover: rst asserted mid-pass then released -> all outputs at reset values, no done pulse, back-to-back pairs then complete at NTAPS+2-cycle spacing.
